// File: rtl/persiana_pkg.sv
// Shared constants for the multi-level blind controller: FSM state encoding
// and default parameter values.
package persiana_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MOVE_UP   = 2'd1;
    localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
    localparam logic [1:0] ST_FAULT     = 2'd3;

    localparam int DEF_NUM_POS       = 4;
    localparam int DEF_PRESCALE      = 25000000;
    localparam int DEF_TIMEOUT_TICKS = 32;
    localparam int DEF_LIGHT_W       = 4;

    // Stall counter width covers the largest legal timeout (255).
    localparam int STALL_W = 8;

endpackage

// File: rtl/persiana_multinivel_tick_gen.sv
// Free-running prescaler producing a registered one-clock enable pulse,
// high during the clock in which the count equals PRESCALE-1.
module tick_gen
    import persiana_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Next count with wrap at PRESCALE-1.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and pulse registers; tick is registered against the next count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/persiana_multinivel.sv
// Multi-level motorised blind controller: command register, position capture,
// stall supervision and the up/down motor FSM, all stepped by the prescaler tick.
module persiana_multinivel
    import persiana_pkg::*;
#(
    parameter int NUM_POS       = DEF_NUM_POS,
    parameter int PRESCALE      = DEF_PRESCALE,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int LIGHT_W       = DEF_LIGHT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    input  logic                       cmd_auto,
    input  logic [$clog2(NUM_POS)-1:0] cmd_pos,
    input  logic [LIGHT_W-1:0]         light,
    input  logic [NUM_POS-1:0]         pos_sensor,
    output logic                       subir,
    output logic                       bajar,
    output logic                       fault,
    output logic [$clog2(NUM_POS)-1:0] cur_pos,
    output logic                       auto_mode,
    output logic                       tick
);

    localparam int                    PW         = $clog2(NUM_POS);
    localparam int                    AW         = LIGHT_W + PW;
    localparam logic [PW:0]           NUM_POS_W  = (PW + 1)'(NUM_POS);
    localparam logic [AW-1:0]         NUM_POS_M  = AW'(NUM_POS);
    localparam logic [PW-1:0]         POS_MAX    = PW'(NUM_POS - 1);
    localparam logic [STALL_W-1:0]    TIMEOUT_W  = STALL_W'(TIMEOUT_TICKS);

    // Returns {exactly_one_bit_set, index_of_set_bit}.
    function automatic logic [PW:0] decode_sensor(input logic [NUM_POS-1:0] s);
        logic [PW-1:0] idx;
        logic [4:0]    cnt;
        idx = '0;
        cnt = 5'd0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (s[i]) begin
                idx = PW'(i);
                cnt = cnt + 5'd1;
            end else begin
                idx = idx;
            end
        end
        return {(cnt == 5'd1), idx};
    endfunction

    logic [1:0]         state_q, state_d;
    logic [PW-1:0]      target_q, target_d;
    logic               auto_q, auto_d;
    logic [PW-1:0]      cur_pos_q, cur_pos_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [STALL_W-1:0] stall_inc;
    logic               subir_q, bajar_q, fault_q;
    logic               tick_s;
    logic [AW-1:0]      light_prod;
    logic [PW-1:0]      auto_tgt;
    logic [PW:0]        sensor_dec;
    logic               pos_change;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick_s)
    );

    // Bright light closes the blind, darkness opens it; the product cannot overflow AW bits.
    assign light_prod = {{PW{1'b0}}, light} * NUM_POS_M;
    assign auto_tgt   = POS_MAX - light_prod[LIGHT_W +: PW];
    assign sensor_dec = decode_sensor(pos_sensor);
    assign stall_inc  = stall_q + STALL_W'(1);

    // Command register: strobes act every clock; out-of-range manual targets are dropped.
    always_comb begin
        auto_d   = auto_q;
        target_d = target_q;
        if (cmd_valid && cmd_auto) begin
            auto_d   = 1'b1;
            target_d = auto_tgt;
        end else if (cmd_valid && ({1'b0, cmd_pos} < NUM_POS_W)) begin
            auto_d   = 1'b0;
            target_d = cmd_pos;
        end else if (auto_q) begin
            target_d = auto_tgt;
        end else begin
            target_d = target_q;
        end
    end

    // Position capture: only an unambiguous single sensor updates the position.
    always_comb begin
        cur_pos_d = cur_pos_q;
        if (tick_s && sensor_dec[PW]) begin
            cur_pos_d = sensor_dec[PW-1:0];
        end else begin
            cur_pos_d = cur_pos_q;
        end
    end

    assign pos_change = (cur_pos_d != cur_pos_q);

    // Motor FSM and stall counter, decided on the pre-edge target and position.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (target_q > cur_pos_q) begin
                        state_d = ST_MOVE_UP;
                        stall_d = '0;
                    end else if (target_q < cur_pos_q) begin
                        state_d = ST_MOVE_DOWN;
                        stall_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MOVE_UP: begin
                    if ((target_q <= cur_pos_q) || pos_sensor[NUM_POS-1]) begin
                        state_d = ST_IDLE;
                    end else if (pos_change) begin
                        stall_d = '0;
                    end else if (stall_inc >= TIMEOUT_W) begin
                        state_d = ST_FAULT;
                        stall_d = stall_inc;
                    end else begin
                        stall_d = stall_inc;
                    end
                end
                ST_MOVE_DOWN: begin
                    if ((target_q >= cur_pos_q) || pos_sensor[0]) begin
                        state_d = ST_IDLE;
                    end else if (pos_change) begin
                        stall_d = '0;
                    end else if (stall_inc >= TIMEOUT_W) begin
                        state_d = ST_FAULT;
                        stall_d = stall_inc;
                    end else begin
                        stall_d = stall_inc;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                    stall_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered outputs; motor drives follow the next state directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            auto_q    <= 1'b0;
            cur_pos_q <= '0;
            stall_q   <= '0;
            subir_q   <= 1'b0;
            bajar_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            auto_q    <= auto_d;
            cur_pos_q <= cur_pos_d;
            stall_q   <= stall_d;
            subir_q   <= (state_d == ST_MOVE_UP);
            bajar_q   <= (state_d == ST_MOVE_DOWN);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    assign subir     = subir_q;
    assign bajar     = bajar_q;
    assign fault     = fault_q;
    assign cur_pos   = cur_pos_q;
    assign auto_mode = auto_q;
    assign tick      = tick_s;

endmodule

// File: tb/tb_persiana_multinivel.sv
// Self-checking bench: command vector table, hand-built motion/fault/reset
// sequences and a randomized run against a tick-level behavioural model.
module tb_persiana_multinivel;

    localparam int NP = 4;
    localparam int PS = 4;
    localparam int TO = 5;
    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_auto = 1'b0;
    logic [1:0] cmd_pos = 2'd0;
    logic [3:0] light = 4'd0, pos_sensor = 4'b0001;
    logic       subir, bajar, fault, auto_mode, tick;
    logic [1:0] cur_pos;

    logic       cmd_valid3 = 1'b0, cmd_auto3 = 1'b0;
    logic [1:0] cmd_pos3 = 2'd0;
    logic [3:0] light3 = 4'd0;
    logic [2:0] pos_sensor3 = 3'b001;
    logic       subir3, bajar3, fault3, auto3, tick3;
    logic [1:0] cur_pos3;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt, m_mode, m_tgt, m_cur, m_stall, m_auto;

    typedef struct {
        logic [3:0] sensor;
        logic       use_auto;
        logic [1:0] pos;
        logic [3:0] lt;
        logic       exp_subir;
        logic       exp_bajar;
        logic       exp_auto;
        logic [1:0] exp_cur;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    persiana_multinivel #(.NUM_POS(NP), .PRESCALE(PS), .TIMEOUT_TICKS(TO), .LIGHT_W(LW)) u_dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_auto(cmd_auto),
        .cmd_pos(cmd_pos), .light(light), .pos_sensor(pos_sensor), .subir(subir),
        .bajar(bajar), .fault(fault), .cur_pos(cur_pos), .auto_mode(auto_mode), .tick(tick)
    );

    persiana_multinivel #(.NUM_POS(3), .PRESCALE(PS), .TIMEOUT_TICKS(TO), .LIGHT_W(LW)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid3), .cmd_auto(cmd_auto3),
        .cmd_pos(cmd_pos3), .light(light3), .pos_sensor(pos_sensor3), .subir(subir3),
        .bajar(bajar3), .fault(fault3), .cur_pos(cur_pos3), .auto_mode(auto3), .tick(tick3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Advance to just after the next clock edge that carries a tick.
    task automatic step_tick();
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (tick) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_wait: got no tick expected tick within 20 clk");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pos(input logic [1:0] p);
        cmd_auto  = 1'b0;
        cmd_pos   = p;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_auto();
        cmd_auto  = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_auto = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_mode = 0; m_tgt = 0; m_cur = 0; m_stall = 0; m_auto = 0;
    endtask

    // Behavioural view of one clock edge: modes 0 idle, 1 up, 2 down, 3 fault.
    task automatic model_step();
        int new_cur;
        int ones;
        if (m_cnt == PS - 1) begin
            ones = 0;
            new_cur = m_cur;
            for (int k = 0; k < NP; k++) begin
                if (pos_sensor[k]) begin
                    ones++;
                    new_cur = k;
                end
            end
            if (ones != 1) new_cur = m_cur;
            case (m_mode)
                0: begin
                    if (m_tgt > m_cur) begin m_mode = 1; m_stall = 0; end
                    else if (m_tgt < m_cur) begin m_mode = 2; m_stall = 0; end
                end
                1, 2: begin
                    if ((m_mode == 1 && (m_tgt <= m_cur || pos_sensor[NP-1])) ||
                        (m_mode == 2 && (m_tgt >= m_cur || pos_sensor[0]))) begin
                        m_mode = 0;
                    end else if (new_cur != m_cur) begin
                        m_stall = 0;
                    end else begin
                        m_stall++;
                        if (m_stall >= TO) m_mode = 3;
                    end
                end
                default: ;
            endcase
            m_cur = new_cur;
        end
        if (cmd_valid && cmd_auto) m_auto = 1;
        else if (cmd_valid && int'(cmd_pos) < NP) begin m_auto = 0; m_tgt = cmd_pos; end
        if (m_auto != 0) m_tgt = NP - 1 - (int'(light) * NP) / (1 << LW);
        m_cnt = (m_cnt + 1) % PS;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        vecs[0] = '{4'b0001, 1'b0, 2'd2, 4'd0,  1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{4'b1000, 1'b0, 2'd0, 4'd0,  1'b0, 1'b1, 1'b0, 2'd3};
        vecs[2] = '{4'b0100, 1'b0, 2'd2, 4'd0,  1'b0, 1'b0, 1'b0, 2'd2};
        vecs[3] = '{4'b0001, 1'b1, 2'd0, 4'd0,  1'b1, 1'b0, 1'b1, 2'd0};
        vecs[4] = '{4'b1000, 1'b1, 2'd0, 4'd15, 1'b0, 1'b1, 1'b1, 2'd3};
        vecs[5] = '{4'b0010, 1'b1, 2'd0, 4'd8,  1'b0, 1'b0, 1'b1, 2'd1};
        vecs[6] = '{4'b0010, 1'b1, 2'd0, 4'd4,  1'b1, 1'b0, 1'b1, 2'd1};
        vecs[7] = '{4'b0100, 1'b1, 2'd0, 4'd12, 1'b0, 1'b1, 1'b1, 2'd2};

        // Reset state
        #3;
        check("rst_subir", subir, 0);
        check("rst_bajar", bajar, 0);
        check("rst_fault", fault, 0);
        check("rst_cur", cur_pos, 0);
        check("rst_auto", auto_mode, 0);
        check("rst_tick", tick, 0);

        // Command vector table, each from a fresh reset with a settled position
        for (int v = 0; v < 8; v++) begin
            do_reset();
            pos_sensor = vecs[v].sensor;
            light      = vecs[v].lt;
            step_tick();
            if (vecs[v].use_auto) send_auto(); else send_pos(vecs[v].pos);
            step_tick();
            check("vec_subir", subir, vecs[v].exp_subir);
            check("vec_bajar", bajar, vecs[v].exp_bajar);
            check("vec_auto", auto_mode, vecs[v].exp_auto);
            check("vec_cur", cur_pos, vecs[v].exp_cur);
        end

        // Full travel upwards, one sensor step per tick
        do_reset();
        pos_sensor = 4'b0001;
        light = 4'd15;
        send_pos(2'd3);
        step_tick();
        check("up_start", subir, 1);
        pos_sensor = 4'b0010; step_tick();
        check("up_p1_subir", subir, 1); check("up_p1_cur", cur_pos, 1);
        pos_sensor = 4'b0100; step_tick();
        check("up_p2_subir", subir, 1); check("up_p2_cur", cur_pos, 2);
        pos_sensor = 4'b1000; step_tick();
        check("up_top_subir", subir, 0); check("up_top_cur", cur_pos, 3);
        step_tick();
        check("up_idle_subir", subir, 0); check("up_idle_bajar", bajar, 0);

        // Auto mode: bright closes, then darkness mid-move reverses via IDLE
        send_auto();
        check("auto_on", auto_mode, 1);
        step_tick();
        check("auto_bajar", bajar, 1);
        pos_sensor = 4'b0100; step_tick();
        check("auto_dn_cur", cur_pos, 2); check("auto_dn_bajar", bajar, 1);
        light = 4'd0; step_tick();
        check("rev_idle_bajar", bajar, 0); check("rev_idle_subir", subir, 0);
        step_tick();
        check("rev_up_subir", subir, 1); check("rev_up_bajar", bajar, 0);

        // Stall timeout with frozen sensor
        do_reset();
        pos_sensor = 4'b0001;
        step_tick();
        send_pos(2'd3);
        step_tick();
        check("stall_enter", subir, 1);
        repeat (4) step_tick();
        check("stall_t4_fault", fault, 0); check("stall_t4_subir", subir, 1);
        step_tick();
        check("stall_t5_fault", fault, 1); check("stall_t5_subir", subir, 0);
        send_pos(2'd0);
        step_tick();
        send_auto();
        step_tick();
        check("flt_hold", fault, 1); check("flt_subir", subir, 0);
        check("flt_bajar", bajar, 0); check("flt_cmd_reg", auto_mode, 1);
        do_reset();
        check("flt_cleared", fault, 0);

        // Out-of-range manual target on a 3-position instance; ambiguous sensors
        pos_sensor3 = 3'b001;
        step_tick();
        cmd_pos3 = 2'd3; cmd_auto3 = 1'b0; cmd_valid3 = 1'b1;
        @(posedge clk); #1 cmd_valid3 = 1'b0;
        step_tick(); step_tick();
        check("np3_subir", subir3, 0); check("np3_bajar", bajar3, 0);
        check("np3_auto", auto3, 0); check("np3_fault", fault3, 0);
        pos_sensor3 = 3'b110; step_tick();
        check("np3_multi_cur", cur_pos3, 0);
        pos_sensor3 = 3'b010; step_tick();
        check("np3_single_cur", cur_pos3, 1);
        pos_sensor3 = 3'b000; step_tick();
        check("np3_none_cur", cur_pos3, 1);
        pos_sensor3 = 3'b001;

        // Asynchronous reset mid-move, then prescaler timing after release
        do_reset();
        pos_sensor = 4'b1000;
        step_tick();
        send_pos(2'd0);
        step_tick();
        check("arst_pre_bajar", bajar, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_bajar", bajar, 0);
        check("arst_cur", cur_pos, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!tick && c < 20);
        check("first_tick_clk", c, 3);
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!tick && c < 20);
        check("tick_period_clk", c, 4);

        // Randomized run against the behavioural model
        for (int i = 0; i < 480; i++) begin
            if (i % 80 == 0) begin
                do_reset();
                model_reset();
            end
            cmd_valid = ($urandom_range(0, 7) == 0);
            cmd_auto  = 1'($urandom_range(0, 1));
            cmd_pos   = 2'($urandom_range(0, 3));
            light     = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) pos_sensor = 4'b0001 << $urandom_range(0, 3);
            else pos_sensor = 4'($urandom_range(0, 15));
            @(posedge clk);
            model_step();
            #1;
            check("rnd_subir", subir, (m_mode == 1));
            check("rnd_bajar", bajar, (m_mode == 2));
            check("rnd_fault", fault, (m_mode == 3));
            check("rnd_cur", cur_pos, m_cur);
            check("rnd_auto", auto_mode, m_auto);
            check("rnd_tick", tick, (m_cnt == PS - 1));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/persiana_multinivel.md
PERSIANA_MULTINIVEL -- requirements
Module: persiana_multinivel

Interface
REQ-001 Parameter NUM_POS, default 4: number of discrete blind positions, index 0 = fully closed (bottom), NUM_POS-1 = fully open (top); legal range 2..16.
REQ-002 Parameter PRESCALE, default 25000000: clk cycles per FSM tick; legal range 2..2^25.
REQ-003 Parameter TIMEOUT_TICKS, default 32: ticks allowed in a move state without a position change before fault; legal range 2..255.
REQ-004 Parameter LIGHT_W, default 4: width of the ambient light input.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock (100 MHz nominal).
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 cmd_valid  input  1  single-clk command strobe.
REQ-009 cmd_auto  input  1  when cmd_valid=1: 1 selects automatic mode, 0 selects manual target cmd_pos.
REQ-010 cmd_pos  input  PW=clog2(NUM_POS)  manual target position.
REQ-011 light  input  LIGHT_W  ambient light level, 0 = dark, all-ones = brightest.
REQ-012 pos_sensor  input  NUM_POS  one limit sensor per position, 1 = blind at that position.
REQ-013 subir  output  1  motor up command.
REQ-014 bajar  output  1  motor down command.
REQ-015 fault  output  1  stall/timeout fault flag.
REQ-016 cur_pos  output  PW  last valid sensed position.
REQ-017 auto_mode  output  1  1 = automatic mode active.
REQ-018 tick  output  1  one-clk pulse per prescaler period.

Function
REQ-019 Prescaler counts 0..PRESCALE-1 on every clk, wraps to 0; tick=1 for exactly the clk in which count = PRESCALE-1; no derived clocks, tick is a clock enable only.
REQ-020 Command register updates on any clk with cmd_valid=1, independent of tick: cmd_auto=1 -> auto_mode=1; cmd_auto=0 and cmd_pos<NUM_POS -> auto_mode=0, target=cmd_pos; cmd_pos>=NUM_POS -> command ignored entirely.
REQ-021 In auto mode target = NUM_POS-1 - ((light*NUM_POS) >> LIGHT_W), recomputed every clk (bright -> closed, dark -> open); arithmetic width LIGHT_W+PW bits, no overflow.
REQ-022 cur_pos updates on tick only, when pos_sensor has exactly one bit set, to that bit index; zero or multiple bits set -> cur_pos holds.
REQ-023 FSM advances on tick only; states IDLE, MOVE_UP, MOVE_DOWN, FAULT; FSM evaluates the target and cur_pos values registered before that edge.
REQ-024 IDLE: target>cur_pos -> MOVE_UP; target<cur_pos -> MOVE_DOWN; equal -> stay.
REQ-025 MOVE_UP: target<=cur_pos or pos_sensor[NUM_POS-1]=1 -> IDLE; MOVE_DOWN: target>=cur_pos or pos_sensor[0]=1 -> IDLE; direct MOVE_UP<->MOVE_DOWN reversal forbidden (at least one tick in IDLE).
REQ-026 Stall counter clears on entry to a move state and on each cur_pos change; increments per tick in a move state; reaching TIMEOUT_TICKS -> FAULT.
REQ-027 FAULT: subir=bajar=0, fault=1; commands still update the command register but FSM leaves FAULT only via reset.
REQ-028 subir=1 only in MOVE_UP, bajar=1 only in MOVE_DOWN; all outputs registered; subir and bajar never 1 simultaneously.

Reset
REQ-029 reset_n=0 asynchronously forces: state IDLE, prescaler 0, stall counter 0, target 0, cur_pos 0, auto_mode 0, subir 0, bajar 0, fault 0, tick 0; reset mid-move stops the motor immediately.

Structure
REQ-030 Package persiana_pkg holds the state enumeration and default parameter constants.
REQ-031 Prescaler is one sub-module, tick_gen (parameter PRESCALE, outputs tick); FSM, command register and stall counter live in persiana_multinivel.

Verification (bench with PRESCALE=4, NUM_POS=4, TIMEOUT_TICKS=5, LIGHT_W=4)
REQ-032 Reset, pos_sensor=0001, cmd_pos=3 strobe, sensors stepped 0010/0100/1000 one per tick -> subir=1 for three position changes, then IDLE, cur_pos=3, subir=0.
REQ-033 At cur_pos=3, cmd_auto=1, light=15 -> target 0, bajar asserted on next tick; light=0 mid-move -> bajar drops, IDLE one tick, then subir=1.
REQ-034 MOVE_UP with pos_sensor frozen at 0001 -> fault=1 exactly 5 ticks after entering MOVE_UP, subir=0; further commands ignored until reset_n pulse.
REQ-035 cmd_pos=3 with NUM_POS=3 instance -> target unchanged, no motion; pos_sensor=0110 -> cur_pos holds.
REQ-036 reset_n asserted between ticks while bajar=1 -> bajar=0 in same clk without waiting for clk edge; tick period exactly 4 clk after release.
